gc_dram_array: RTL and testbench

GC_DRAM_ARRAY -- requirements
Module: gc_dram_array

---
 rtl/gc_dram_array.sv | 176 +++++++++++++++++
 tb/tb_gc_dram_array.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gc_dram_array.sv
// gc_dram_array: behavioural model of a gain-cell DRAM array whose rows lose
// their contents RETENTION cycles after the last write or refresh.
//
// Ports:
//   clk       single clock, all state updates on the rising edge
//   rst       asynchronous active-high reset
//   we/waddr/wdata     row write
//   re/raddr           row read, rdata/rerr registered, rvalid pulses one cycle later
//   rdata/rvalid/rerr  read response (rerr = empty, expired or colliding row)
//   ref_en/ref_addr    row refresh request
//   ref_err            one-cycle pulse, refresh aimed at a row that is not LIVE
//   fail               sticky, some LIVE row expired since reset
module gc_dram_array #(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 128,
    parameter int RETENTION    = 5000,
    parameter int COLLIDE_MODE = 0,
    localparam int AW          = $clog2(DEPTH),
    localparam int CW          = $clog2(RETENTION + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             rerr,
    input  logic             ref_en,
    input  logic [AW-1:0]    ref_addr,
    output logic             ref_err,
    output logic             fail
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LIVE    = 2'd1,
        ST_EXPIRED = 2'd2
    } row_state_t;

    localparam logic [CW-1:0] RET_LOAD  = CW'(RETENTION);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r   [DEPTH];
    row_state_t       state_r [DEPTH];
    logic [CW-1:0]    cnt_r   [DEPTH];

    logic             wr_ok_s;
    logic             rf_ok_s;
    logic             rd_ok_s;
    logic             collide_s;
    logic             ref_live_s;
    logic             ref_err_nx_s;
    logic [DEPTH-1:0] wr_hit_s;
    logic [DEPTH-1:0] ref_hit_s;
    logic [DEPTH-1:0] expire_s;
    logic [WIDTH-1:0] rd_data_nx_s;
    logic             rd_err_nx_s;

    // Address qualification: out-of-range rows exist only when DEPTH is not a power of two.
    always_comb begin
        wr_ok_s   = we && ({1'b0, waddr} < DEPTH_LIM);
        rf_ok_s   = ref_en && ({1'b0, ref_addr} < DEPTH_LIM);
        rd_ok_s   = ({1'b0, raddr} < DEPTH_LIM);
        collide_s = re && wr_ok_s && (raddr == waddr);
    end

    // Per-row decode of write hits, LIVE refresh hits and this-edge expiries.
    always_comb begin
        wr_hit_s  = '0;
        ref_hit_s = '0;
        expire_s  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_hit_s[i]  = wr_ok_s && (waddr == AW'(i));
            ref_hit_s[i] = rf_ok_s && (ref_addr == AW'(i)) && (state_r[i] == ST_LIVE);
            // A row expires only if nothing reloads its counter at this edge.
            expire_s[i]  = (state_r[i] == ST_LIVE) && (cnt_r[i] == CNT_ONE) &&
                           !wr_hit_s[i] && !ref_hit_s[i];
        end
    end

    // Refresh status: a write to the same row at the same edge counts as success.
    always_comb begin
        ref_live_s = 1'b0;
        if (rf_ok_s) begin
            ref_live_s = (state_r[ref_addr] == ST_LIVE);
        end else begin
            ref_live_s = 1'b0;
        end
        ref_err_nx_s = ref_en && !ref_live_s && !(wr_ok_s && (waddr == ref_addr));
    end

    // Read response selection from pre-edge array state.
    always_comb begin
        rd_data_nx_s = {WIDTH{1'bx}};
        rd_err_nx_s  = 1'b1;
        if (collide_s) begin
            if (COLLIDE_MODE == 1) begin
                rd_data_nx_s = wdata;
                rd_err_nx_s  = 1'b0;
            end else begin
                rd_data_nx_s = {WIDTH{1'bx}};
                rd_err_nx_s  = 1'b1;
            end
        end else if (rd_ok_s && (state_r[raddr] == ST_LIVE)) begin
            rd_data_nx_s = mem_r[raddr];
            rd_err_nx_s  = 1'b0;
        end else begin
            rd_data_nx_s = {WIDTH{1'bx}};
            rd_err_nx_s  = 1'b1;
        end
    end

    // Row state and retention counters; all LIVE rows age in parallel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_r[i] <= ST_EMPTY;
                cnt_r[i]   <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit_s[i]) begin
                    state_r[i] <= ST_LIVE;
                    cnt_r[i]   <= RET_LOAD;
                end else if (ref_hit_s[i]) begin
                    cnt_r[i]   <= RET_LOAD;
                end else if (expire_s[i]) begin
                    state_r[i] <= ST_EXPIRED;
                    cnt_r[i]   <= CNT_ZERO;
                end else if (state_r[i] == ST_LIVE) begin
                    cnt_r[i]   <= cnt_r[i] - CNT_ONE;
                end else begin
                    cnt_r[i]   <= CNT_ZERO;
                end
            end
        end
    end

    // Row data: contents are undefined after reset and poisoned on expiry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_hit_s[i]) begin
                mem_r[i] <= wdata;
            end else if (expire_s[i]) begin
                mem_r[i] <= {WIDTH{1'bx}};
            end
        end
    end

    // Registered outputs: read response, refresh error pulse and sticky fail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata   <= '0;
            rvalid  <= 1'b0;
            rerr    <= 1'b0;
            ref_err <= 1'b0;
            fail    <= 1'b0;
        end else begin
            rvalid  <= re;
            if (re) begin
                rdata <= rd_data_nx_s;
                rerr  <= rd_err_nx_s;
            end else begin
                rerr  <= 1'b0;
            end
            ref_err <= ref_err_nx_s;
            fail    <= fail | (|expire_s);
        end
    end

endmodule

// File: tb/tb_gc_dram_array.sv
// Scoreboard bench for gc_dram_array: two instances (collision mode 0 and 1)
// share stimulus; expected read responses are queued per instance and popped
// by a monitor whenever rvalid is seen.
module tb_gc_dram_array;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int R  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          we, re, ref_en;
    logic [AW-1:0] waddr, raddr, ref_addr;
    logic [W-1:0]  wdata;

    logic [W-1:0]  rdata0, rdata1;
    logic          rvalid0, rvalid1, rerr0, rerr1, ref_err0, ref_err1, fail0, fail1;

    typedef struct {
        bit          chk_data;
        logic [W-1:0] data;
        logic        err;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   tests = 0;
    int   fails = 0;

    gc_dram_array #(.WIDTH(W), .DEPTH(D), .RETENTION(R), .COLLIDE_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0), .rerr(rerr0),
        .ref_en(ref_en), .ref_addr(ref_addr), .ref_err(ref_err0), .fail(fail0)
    );

    gc_dram_array #(.WIDTH(W), .DEPTH(D), .RETENTION(R), .COLLIDE_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .rerr(rerr1),
        .ref_en(ref_en), .ref_addr(ref_addr), .ref_err(ref_err1), .fail(fail1)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every read response of either instance.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid0 === 1'b1) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL m0_unexpected_rvalid: got rvalid=1 expected no response");
            end else begin
                e = q0.pop_front();
                check({e.name, "_m0_rerr"}, 32'(rerr0), 32'(e.err));
                if (e.chk_data) check({e.name, "_m0_rdata"}, 32'(rdata0), 32'(e.data));
            end
        end
        if (rvalid1 === 1'b1) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL m1_unexpected_rvalid: got rvalid=1 expected no response");
            end else begin
                e = q1.pop_front();
                check({e.name, "_m1_rerr"}, 32'(rerr1), 32'(e.err));
                if (e.chk_data) check({e.name, "_m1_rdata"}, 32'(rdata1), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_both(input string name, input bit chk, input logic [W-1:0] d, input logic err);
        exp_t e;
        e.name = name; e.chk_data = chk; e.data = d; e.err = err;
        q0.push_back(e);
        q1.push_back(e);
    endtask

    task automatic rd(input logic [AW-1:0] a, input string name, input bit chk,
                      input logic [W-1:0] d, input logic err);
        re = 1'b1; raddr = a;
        push_both(name, chk, d, err);
        tick();
        re = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic refresh(input logic [AW-1:0] a);
        ref_en = 1'b1; ref_addr = a;
        tick();
        ref_en = 1'b0;
    endtask

    task automatic check_reset_outs(input string name);
        check({name, "_m0"}, {12'd0, rvalid0, rerr0, ref_err0, fail0, rdata0}, 32'd0);
        check({name, "_m1"}, {12'd0, rvalid1, rerr1, ref_err1, fail1, rdata1}, 32'd0);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; we = 1'b0; re = 1'b0; ref_en = 1'b0;
        waddr = '0; raddr = '0; ref_addr = '0; wdata = '0;
        #12;
        check_reset_outs("reset_state");
        rst = 1'b0;

        // Empty row read
        rd(4'd3, "empty_row3", 1'b0, 16'h0000, 1'b1);
        check("fail_after_empty_read", 32'(fail0), 32'd0);

        // Retention boundary on row 2: write at T, last good read at T+8
        wr(4'd2, 16'hA5A5);
        repeat (7) tick();
        check("fail_before_expiry", 32'(fail0), 32'd0);
        rd(4'd2, "row2_last_live", 1'b1, 16'hA5A5, 1'b0);
        check("fail_at_expiry_m0", 32'(fail0), 32'd1);
        check("fail_at_expiry_m1", 32'(fail1), 32'd1);
        rd(4'd2, "row2_expired", 1'b0, 16'h0000, 1'b1);
        tick();
        check("fail_sticky", 32'(fail0), 32'd1);

        // Refresh keeps row 5 alive, including refresh at counter==1
        wr(4'd5, 16'h5A5A);
        repeat (7) tick();
        refresh(4'd5);
        check("ref_live_no_err", 32'(ref_err0), 32'd0);
        repeat (6) tick();
        refresh(4'd5);
        repeat (7) tick();
        rd(4'd5, "row5_refreshed", 1'b1, 16'h5A5A, 1'b0);
        rd(4'd5, "row5_expired", 1'b0, 16'h0000, 1'b1);

        // Refresh of an EMPTY row pulses ref_err for one cycle
        refresh(4'd6);
        check("ref_empty_err_m0", 32'(ref_err0), 32'd1);
        check("ref_empty_err_m1", 32'(ref_err1), 32'd1);
        tick();
        check("ref_err_pulse_end", 32'(ref_err0), 32'd0);

        // Same-row read/write collision
        we = 1'b1; waddr = 4'd7; wdata = 16'h1234; re = 1'b1; raddr = 4'd7;
        e.name = "collide"; e.chk_data = 1'b0; e.data = 16'h0000; e.err = 1'b1;
        q0.push_back(e);
        e.chk_data = 1'b1; e.data = 16'h1234; e.err = 1'b0;
        q1.push_back(e);
        tick();
        we = 1'b0; re = 1'b0;
        rd(4'd7, "after_collide", 1'b1, 16'h1234, 1'b0);
        tick();
        check("idle_rvalid_low", 32'(rvalid0), 32'd0);
        check("idle_rerr_low", 32'(rerr0), 32'd0);
        check("idle_rdata_hold_m0", 32'(rdata0), 32'h1234);
        check("idle_rdata_hold_m1", 32'(rdata1), 32'h1234);

        // Write and refresh on the same EMPTY row: write wins, no error
        we = 1'b1; waddr = 4'd9; wdata = 16'h0909; ref_en = 1'b1; ref_addr = 4'd9;
        tick();
        we = 1'b0; ref_en = 1'b0;
        check("wr_ref_same_row_err", 32'(ref_err0), 32'd0);
        // Write one row while refreshing a different EMPTY row
        we = 1'b1; waddr = 4'd10; wdata = 16'h0A0A; ref_en = 1'b1; ref_addr = 4'd11;
        tick();
        we = 1'b0; ref_en = 1'b0;
        check("wr_ref_diff_row_err", 32'(ref_err0), 32'd1);
        rd(4'd9, "row9_written", 1'b1, 16'h0909, 1'b0);
        rd(4'd10, "row10_written", 1'b1, 16'h0A0A, 1'b0);

        // Fill the array, then reset asynchronously with a read in flight
        for (int i = 0; i < D; i++) begin
            wr(AW'(i), 16'h1000 + 16'(i));
        end
        re = 1'b1; raddr = 4'd0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outs("async_reset");
        tick();
        re = 1'b0;
        #2;
        rst = 1'b0;
        rd(4'd0, "post_reset_row0", 1'b0, 16'h0000, 1'b1);
        rd(4'd15, "post_reset_row15", 1'b0, 16'h0000, 1'b1);
        repeat (2) tick();
        check("queue0_drained", 32'(q0.size()), 32'd0);
        check("queue1_drained", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
